// File: rtl/weapons_pkg.sv
// Shared types and helpers for the multi-channel weapon bank.
package weapons_pkg;

   typedef enum logic [1:0] {
      ST_READY  = 2'd0,
      ST_COOL   = 2'd1,
      ST_RELOAD = 2'd2
   } chan_state_e;

   localparam logic [3:0] ATTACK_MODE = 4'b0010;

   // Subtract that clamps at zero instead of wrapping.
   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
      return (a >= b) ? (a - b) : 32'd0;
   endfunction

endpackage

// File: rtl/weapon_channel.sv
// One weapon channel: magazine, READY/COOL/RELOAD FSM, registered status outputs.
module weapon_channel
   import weapons_pkg::*;
#(
   parameter int AW          = 9,
   parameter int CW          = 4,
   parameter int RELOAD_CYC  = 8,
   parameter int MAX_DEFAULT = 500
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fire,
   input  logic          reload,
   input  logic          attack,
   input  logic          load_max,
   input  logic [AW-1:0] max_in,
   input  logic [AW-1:0] capacity,
   input  logic [AW-1:0] fire_rate,
   input  logic [CW-1:0] cooldown,
   output logic [AW-1:0] ammo,
   output logic          shot,
   output logic          error,
   output logic          empty,
   output chan_state_e   state
);

   localparam int RW = $clog2(RELOAD_CYC + 1);
   localparam logic [RW-1:0] RELOAD_LOAD = RW'(RELOAD_CYC);
   localparam logic [AW-1:0] AMMO_RST    = AW'(MAX_DEFAULT);

   chan_state_e   state_n;
   logic [AW-1:0] ammo_n;
   logic [AW-1:0] rate;
   logic [CW-1:0] cool_cnt, cool_n;
   logic [RW-1:0] rel_cnt, rel_n;
   logic          shot_n, error_n, empty_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_READY;
         ammo     <= AMMO_RST;
         cool_cnt <= '0;
         rel_cnt  <= '0;
         shot     <= 1'b0;
         error    <= 1'b0;
         empty    <= (MAX_DEFAULT == 0);
      end else begin
         state    <= state_n;
         ammo     <= ammo_n;
         cool_cnt <= cool_n;
         rel_cnt  <= rel_n;
         shot     <= shot_n;
         error    <= error_n;
         empty    <= empty_n;
      end
   end

   always_comb begin
      state_n = state;
      ammo_n  = ammo;
      cool_n  = cool_cnt;
      rel_n   = rel_cnt;
      shot_n  = 1'b0;
      error_n = 1'b0;
      rate    = (fire_rate == '0) ? AW'(1) : fire_rate;

      case (state)
         ST_READY: begin
            // Reload wins over fire; a fire in the same cycle is dropped silently.
            if (reload) begin
               state_n = ST_RELOAD;
               rel_n   = RELOAD_LOAD;
            end else if (fire) begin
               if (attack && (ammo != '0)) begin
                  ammo_n = AW'(sat_sub(32'(ammo), 32'(rate)));
                  shot_n = 1'b1;
                  if (cooldown != '0) begin
                     state_n = ST_COOL;
                     cool_n  = cooldown;
                  end
               end else begin
                  error_n = 1'b1;
               end
            end
         end
         ST_COOL: begin
            if (reload) begin
               state_n = ST_RELOAD;
               rel_n   = RELOAD_LOAD;
               cool_n  = '0;
            end else begin
               error_n = fire;
               cool_n  = cool_cnt - CW'(1);
               if (cool_cnt <= CW'(1)) state_n = ST_READY;
            end
         end
         ST_RELOAD: begin
            error_n = fire;
            rel_n   = rel_cnt - RW'(1);
            if (rel_cnt <= RW'(1)) begin
               ammo_n  = capacity;
               state_n = ST_READY;
            end
         end
         default: state_n = ST_READY;
      endcase

      // A new capacity clamps whatever this edge would otherwise have loaded.
      if (load_max && (ammo_n > max_in)) ammo_n = max_in;
      empty_n = (ammo_n == '0);
   end

endmodule

// File: rtl/weapon_bank.sv
// NCH independent weapon channels sharing mode decode, fire parameters and capacity.
module weapon_bank
   import weapons_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int AW          = 9,
   parameter int CW          = 4,
   parameter int RELOAD_CYC  = 8,
   parameter int MAX_DEFAULT = 500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        mode_selector,
   input  logic [NCH-1:0]    fire,
   input  logic [NCH-1:0]    reload,
   input  logic              load_max,
   input  logic [AW-1:0]     max_in,
   input  logic [AW-1:0]     fire_rate,
   input  logic [CW-1:0]     cooldown,
   output logic [NCH*AW-1:0] ammo,
   output logic [NCH-1:0]    shot,
   output logic [NCH-1:0]    busy,
   output logic [NCH-1:0]    empty,
   output logic [NCH-1:0]    error
);

   logic          attack;
   logic [AW-1:0] capacity;
   chan_state_e   ch_state [NCH];

   // Multi-hot or all-zero selectors are never attack.
   assign attack = (mode_selector == ATTACK_MODE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) capacity <= AW'(MAX_DEFAULT);
      else if (load_max) capacity <= max_in;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      weapon_channel #(
         .AW          (AW),
         .CW          (CW),
         .RELOAD_CYC  (RELOAD_CYC),
         .MAX_DEFAULT (MAX_DEFAULT)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .fire      (fire[i]),
         .reload    (reload[i]),
         .attack    (attack),
         .load_max  (load_max),
         .max_in    (max_in),
         .capacity  (capacity),
         .fire_rate (fire_rate),
         .cooldown  (cooldown),
         .ammo      (ammo[i*AW +: AW]),
         .shot      (shot[i]),
         .error     (error[i]),
         .empty     (empty[i]),
         .state     (ch_state[i])
      );
      // State is a flop, so busy stays a registered output.
      assign busy[i] = (ch_state[i] != ST_READY);
   end

endmodule
